// File: rtl/sll_pkg.sv
// Shared types and constants for the iterative logical left shifter.
package sll_pkg;

  localparam int SLL_WIDTH  = 32;
  localparam int SLL_SHW    = 5;
  localparam int SLL_STAGES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sll_stage.sv
// One power-of-two left-shift stage: shifts by 2^k when enabled, zero-filled.
module sll_stage #(
  parameter int WIDTH = 32,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted_s;

  assign shifted_s = data_i << (32'd1 << k_i);
  assign data_o    = en_i ? shifted_s : data_i;

endmodule

// File: rtl/sll_iter.sv
// Iterative 32-bit logical left shifter, one stage (16,8,4,2,1) per clock.
// Optional macro SLL_ITER_EARLY_EXIT_EN finishes as soon as no lower shamt bits remain.
module sll_iter
  import sll_pkg::*;
#(
  parameter int WIDTH = SLL_WIDTH,
  parameter int SHW   = SLL_SHW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  localparam int KW = $clog2(SHW);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] out_q;
  logic [SHW-1:0]   shamt_q;
  logic [KW-1:0]    cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             ready_q;

  logic [WIDTH-1:0] stg_in_s;
  logic [KW-1:0]    stg_k_s;
  logic [SHW-1:0]   shamt_sel_s;
  logic             stg_en_s;
  logic [WIDTH-1:0] data_d;
  logic             last_s;

  // The accept cycle reuses the stage for the 16-step directly on the inputs
  always_comb begin
    if (state_q == IDLE) begin
      stg_in_s    = i_data;
      stg_k_s     = KW'(SHW - 1);
      shamt_sel_s = i_shamt;
    end else begin
      stg_in_s    = data_q;
      stg_k_s     = cnt_q;
      shamt_sel_s = shamt_q;
    end
  end

  assign stg_en_s = shamt_sel_s[stg_k_s];

  sll_stage #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_stage (
    .data_i (stg_in_s),
    .k_i    (stg_k_s),
    .en_i   (stg_en_s),
    .data_o (data_d)
  );

`ifdef SLL_ITER_EARLY_EXIT_EN
  logic [SHW-1:0] low_mask_s;
  assign low_mask_s = (SHW'(1) << stg_k_s) - SHW'(1);
  assign last_s     = ((shamt_sel_s & low_mask_s) == '0);
`else
  assign last_s     = (state_q == SHIFT) && (cnt_q == '0);
`endif

  // Control FSM with registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      out_q   <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            shamt_q <= i_shamt;
            data_q  <= data_d;
            cnt_q   <= KW'(SLL_STAGES - 2);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (last_s) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              out_q   <= data_d;
            end else begin
              state_q <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - KW'(1);
          if (last_s) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            out_q   <= data_d;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_data  = out_q;

endmodule

// File: tb/tb_sll_iter.sv
// Scoreboard bench for sll_iter: directed vectors, backpressure, flush and async reset.
module tb_sll_iter;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] i_data, o_data;
  logic [4:0]  i_shamt;

  sll_iter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_shamt (i_shamt),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] e;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_drop = 1'b0;
  bit   seen = 1'b0;

  always @(posedge i_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] sh);
`ifdef SLL_ITER_EARLY_EXIT_EN
    for (int j = 0; j < 5; j++) begin
      if (sh[j]) return 5 - j;
    end
    return 1;
`else
    return 5;
`endif
  endfunction

  // Monitor: compares every presented result against the head of the scoreboard
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (chk_drop) begin
        chk("valid_drop", 32'(o_valid), 32'd0);
        chk("ready_after", 32'(o_ready), 32'd1);
        chk_drop = 1'b0;
      end
      if (o_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got o_valid=1 o_data=0x%08h expected no result", o_data);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            seen = 1'b1;
          end
          chk("data", o_data, sb[0].data);
          chk("ready_low", 32'(o_ready), 32'd0);
          chk("busy_high", 32'(o_busy), 32'd1);
          if (i_ready) begin
            void'(sb.pop_front());
            seen     = 1'b0;
            chk_drop = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [31:0] e, input bit push);
    int t = 0;
    while (o_ready !== 1'b1 && t < 50) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got o_ready=%0b expected 1", o_ready);
    end
    i_valid = 1'b1;
    i_data  = d;
    i_shamt = sh;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    if (push) sb.push_back('{data: e, acc: cyc, lat: exp_lat(sh)});
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) begin @(posedge i_clk); #1; end
  endtask

  vec_t vecs[$];

  initial begin
    int t;
    vecs = '{
      '{32'h0000_0001, 5'd31, 32'h8000_0000},
      '{32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0},
      '{32'h1234_5678, 5'd0,  32'h1234_5678},
      '{32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000},
      '{32'h0000_0100, 5'd8,  32'h0001_0000},
      '{32'h8000_0001, 5'd1,  32'h0000_0002},
      '{32'h0F0F_0F0F, 5'd13, 32'hE1E1_E000},
      '{32'hC000_0003, 5'd2,  32'h0000_000C}
    };
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_data  = 32'd0; i_shamt = 5'd0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", o_data, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    foreach (vecs[i]) issue(vecs[i].d, vecs[i].sh, vecs[i].e, 1'b1);
    drain();

    // Backpressure with an ignored second request
    i_ready = 1'b0;
    issue(32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b1);
    t = 0;
    while (o_valid !== 1'b1 && t < 50) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk("bp_valid_seen", 32'(o_valid), 32'd1);
    i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_shamt = 5'd3;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("bp_ready_low", 32'(o_ready), 32'd0);
      chk("bp_data_hold", o_data, 32'h0000_FF00);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_release_busy", 32'(o_busy), 32'd0);
    drain();

    // Flush in the third SHIFT cycle
    issue(32'h0000_0001, 5'd1, 32'h0, 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush_ready", 32'(o_ready), 32'd1);
    chk("flush_busy", 32'(o_busy), 32'd0);
    chk("flush_valid", 32'(o_valid), 32'd0);
    repeat (8) begin @(posedge i_clk); #1; end

    // Flush wins over a simultaneous request
    i_flush = 1'b1; i_valid = 1'b1; i_data = 32'h0000_0005; i_shamt = 5'd2;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flushv_busy", 32'(o_busy), 32'd0);
    chk("flushv_ready", 32'(o_ready), 32'd1);
    repeat (8) begin @(posedge i_clk); #1; end
    chk("flushv_busy_later", 32'(o_busy), 32'd0);

    // Asynchronous reset between edges mid-SHIFT
    issue(32'h0000_0003, 5'd1, 32'h0, 1'b0);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    issue(32'h0000_0003, 5'd1, 32'h0000_0006, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sll_iter.md
Name: sll_iter

Overview:
- Iterative 32-bit logical left shifter. It is the left-shift counterpart of the ALU's arithmetic right shifter.
- Applies one power-of-two shift stage per clock, in the order 16, 8, 4, 2, 1, using a single reusable stage datapath.
- Used by the multi-cycle execute path for SLL/SLLI. Valid/ready handshake on input and output; synchronous flush for pipeline kill.

Parameters:
- WIDTH, 32, data width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous abort of any operation in flight.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request.
- i_data  input  WIDTH  operand to shift.
- i_shamt  input  SHW  shift amount, 0..WIDTH-1.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_data  output  WIDTH  shifted result.
- o_busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; data register, shamt register and stage counter cleared.
  - o_valid=0, o_data=0, o_busy=0, o_ready=1.
  - Takes effect immediately, including mid-operation.
- States:
  - IDLE: o_ready=1.
  - SHIFT: o_ready=0, o_busy=1.
  - DONE: o_ready=0, o_valid=1, o_busy=1.
- Accept: on an edge where state=IDLE, i_valid=1 and i_flush=0.
  - Latch shamt.
  - Load the data register with i_data shifted left by 16 if i_shamt[4]=1, else i_data unchanged.
  - Set the stage counter to 3 and go to SHIFT.
- SHIFT, each edge:
  - Data register <= data shifted left by 2^k if shamt[k]=1, else unchanged; k = stage counter.
  - The counter decrements. After the k=0 stage, go to DONE.
- Fill and width rules:
  - Vacated LSBs fill with 0; bits shifted past MSB are discarded.
  - No sign handling; a shift of 0 returns i_data unchanged.
- Latency without the optional feature: fixed. Accept in cycle C gives first o_valid in cycle C+5.
- DONE:
  - o_data = data register, held stable while o_valid=1 and i_ready=0.
  - On i_ready=1, go to IDLE; o_valid=0 next cycle.
  - A new request is accepted no earlier than the cycle after the output handshake. Back-to-back throughput is 1 result per 6 cycles minimum.
- i_flush=1, from any state: next state is IDLE and o_valid is 0 next cycle. A result pending in DONE is discarded.
- i_flush has priority over accept: i_valid in the flush cycle is not accepted.
- o_data in IDLE: holds the last computed value. Verification must not check o_data when o_valid=0.

Optional Feature:
- Macro: SLL_ITER_EARLY_EXIT_EN.
- Defined: after applying stage k (including the stage-16 step at accept), if shamt[k-1:0]==0 (or k=0), go directly to DONE.
  - Latency = 5-j, where j is the index of the lowest set bit of shamt.
  - shamt=0 gives latency 1.
  - Results are identical to the non-macro build.
- Undefined: latency is always 5 regardless of shamt.

Decomposition:
- Package sll_pkg:
  - state_e enum typedef (IDLE, SHIFT, DONE).
  - SLL_WIDTH=32 and SLL_SHW=5 constants.
  - Stage-count constant SLL_STAGES=5.
- Sub-module sll_stage: combinational, one stage.
  - Ports: data in, distance select k, enable bit, data out.
  - Built as one row of mux2 cells, zero-filled.
  - Instantiated once and reused each cycle.

Test Plan:
- i_data=0x0000_0001, i_shamt=31, i_ready=1 -> o_data=0x8000_0000, o_valid first high 5 cycles after the accept cycle, held for exactly 1 cycle.
- i_data=0xFFFF_FFFF, i_shamt=4 -> o_data=0xFFFF_FFF0 (zero fill, no sign extension). Then i_data=0x1234_5678, i_shamt=0 -> o_data=0x1234_5678.
- Backpressure: i_data=0x0000_00FF, i_shamt=8, i_ready=0 for 3 cycles after o_valid -> o_data=0x0000_FF00 stable, o_ready=0, a second i_valid is ignored. i_ready=1 -> o_valid drops next cycle, o_ready=1.
- i_flush=1 in the 3rd SHIFT cycle -> o_valid never asserted, o_ready=1 next cycle. i_flush=1 together with i_valid=1 in IDLE -> request not accepted, o_busy stays 0.
- i_rst_n low asynchronously mid-SHIFT (between edges) -> o_busy=0, o_valid=0, o_ready=1 immediately. After release, a new request (0x0000_0003, shamt 1) -> 0x0000_0006.
- SLL_ITER_EARLY_EXIT_EN defined: shamt=0 -> latency 1; shamt=8 -> latency 2; shamt=16 -> latency 1; shamt=1 -> latency 5. Results match the non-macro build.
